// File: rtl/sort_slot_scheduler_pkg.sv
// Shared definitions for the sort-slot scheduler: index/record widths,
// record field offsets and the scheduler state encoding.
package sort_slot_scheduler_pkg;

  localparam int unsigned PORT_NUB_DEF   = 8;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  localparam int unsigned IDX_W      = $clog2(PORT_NUB_DEF);
  localparam int unsigned WIDTH_PORT = 1 + 2 * IDX_W + DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned width_port(input int unsigned n, input int unsigned dw);
    return 1 + 2 * idx_w(n) + dw;
  endfunction

  // Record layout MSB..LSB: valid | dst | src | data
  function automatic int unsigned src_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned n, input int unsigned dw);
    return dw + idx_w(n);
  endfunction

  function automatic int unsigned valid_bit(input int unsigned n, input int unsigned dw);
    return dw + 2 * idx_w(n);
  endfunction

endpackage

// File: rtl/sort_slot_scheduler_if.sv
// Request, sorter and delivery buses of the sort-slot scheduler.
interface sort_slot_scheduler_if
  import sort_slot_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB   = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IW = idx_w(PORT_NUB);
  localparam int unsigned WP = width_port(PORT_NUB, DATA_WIDTH);

  logic [PORT_NUB-1:0]            req_valid;
  logic [PORT_NUB-1:0]            req_ready;
  logic [PORT_NUB*IW-1:0]         req_dst;
  logic [PORT_NUB*DATA_WIDTH-1:0] req_data;
  logic [PORT_NUB*WP-1:0]         sort_in;
  logic [PORT_NUB*WP-1:0]         sort_out;
  logic [PORT_NUB-1:0]            out_valid;
  logic [PORT_NUB*IW-1:0]         out_src;
  logic [PORT_NUB*DATA_WIDTH-1:0] out_data;

  modport master (
    output req_valid, req_dst, req_data, sort_out,
    input  req_ready, sort_in, out_valid, out_src, out_data
  );

  modport slave (
    input  req_valid, req_dst, req_data, sort_out,
    output req_ready, sort_in, out_valid, out_src, out_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter
  import sort_slot_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB = 8
) (
  input  logic [PORT_NUB-1:0]          req,
  input  logic [idx_w(PORT_NUB)-1:0]   ptr,
  output logic [PORT_NUB-1:0]          grant
);
  localparam int unsigned IW = idx_w(PORT_NUB);

  logic [IW-1:0] idx;
  logic          found;

  // PORT_NUB is a power of two, so IW-bit wrap gives the modulo
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < PORT_NUB; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sort_slot_scheduler.sv
// Crossbar slot scheduler feeding an external sorter; SORT_SCHED_STATS_EN
// enables the grant/block statistics counters (tied to zero otherwise).
module sort_slot_scheduler
  import sort_slot_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB     = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SORT_LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sched_en,
  sort_slot_scheduler_if.slave  bus,
  output logic                  busy,
  output logic                  dup_err,
  output logic [31:0]           stat_grant_cnt,
  output logic [31:0]           stat_block_cnt
);
  localparam int unsigned IW   = idx_w(PORT_NUB);
  localparam int unsigned WP   = width_port(PORT_NUB, DATA_WIDTH);
  localparam int unsigned SRCL = src_lsb(DATA_WIDTH);
  localparam int unsigned DSTL = dst_lsb(PORT_NUB, DATA_WIDTH);
  localparam int unsigned VB   = valid_bit(PORT_NUB, DATA_WIDTH);

  sched_state_e state, state_nxt;
  logic run, issued, in_flight, tok_exit, dup_nxt;

  logic [PORT_NUB-1:0]            req_vec   [PORT_NUB];
  logic [PORT_NUB-1:0]            grant_mat [PORT_NUB];
  logic [IW-1:0]                  rr_ptr    [PORT_NUB];
  logic [PORT_NUB-1:0]            granted;
  logic [SORT_LATENCY-1:0]        tok;
  logic [PORT_NUB*WP-1:0]         sort_in_q;
  logic [PORT_NUB-1:0]            ov_q, ov_nxt;
  logic [PORT_NUB*IW-1:0]         os_q, os_nxt;
  logic [PORT_NUB*DATA_WIDTH-1:0] od_q, od_nxt;
  logic [WP-1:0]                  rec;
  logic [IW-1:0]                  rec_dst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sched_en)   state_nxt = RUN;
      RUN:     if (!sched_en)  state_nxt = DRAIN;
      DRAIN:   if (!in_flight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    run  = (state == RUN);
  end

  always_comb begin
    for (int unsigned d = 0; d < PORT_NUB; d++) begin
      req_vec[d] = '0;
      for (int unsigned i = 0; i < PORT_NUB; i++)
        req_vec[d][i] = run && bus.req_valid[i] && (bus.req_dst[i*IW +: IW] == IW'(d));
    end
  end

  for (genvar d = 0; d < PORT_NUB; d++) begin : g_dst
    rr_arbiter #(.PORT_NUB(PORT_NUB)) u_arb (
      .req   (req_vec[d]),
      .ptr   (rr_ptr[d]),
      .grant (grant_mat[d])
    );
  end

  always_comb begin
    granted = '0;
    for (int unsigned d = 0; d < PORT_NUB; d++) granted = granted | grant_mat[d];
  end
  assign bus.req_ready = granted;

  always_ff @(posedge clk) begin
    for (int unsigned d = 0; d < PORT_NUB; d++) begin
      if (rst) rr_ptr[d] <= '0;
      else
        for (int unsigned i = 0; i < PORT_NUB; i++)
          if (grant_mat[d][i]) rr_ptr[d] <= IW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      if (!rst && granted[i])
        sort_in_q[i*WP +: WP] <= {1'b1, bus.req_dst[i*IW +: IW], IW'(i),
                                  bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]};
      else
        sort_in_q[i*WP +: WP] <= {1'b0, {IW{1'b0}}, IW'(i), {DATA_WIDTH{1'b0}}};
    end
  end
  assign bus.sort_in = sort_in_q;

  // Tokens follow the registered sort_in, so the last token lines up with
  // the sorter's output; a just-issued sort_in also counts as in flight.
  always_comb begin
    issued = 1'b0;
    for (int unsigned i = 0; i < PORT_NUB; i++) issued = issued | sort_in_q[i*WP + VB];
  end

  always_ff @(posedge clk) begin
    if (rst) tok <= '0;
    else begin
      tok[0] <= issued;
      for (int unsigned k = 1; k < SORT_LATENCY; k++) tok[k] <= tok[k-1];
    end
  end

  assign in_flight = issued || (|tok);
  assign tok_exit  = tok[SORT_LATENCY-1];

  // Ascending lane scan: first claim on a destination wins, later ones flag dup
  always_comb begin
    ov_nxt  = '0;
    os_nxt  = os_q;
    od_nxt  = od_q;
    dup_nxt = 1'b0;
    rec     = '0;
    rec_dst = '0;
    if (tok_exit) begin
      for (int unsigned i = 0; i < PORT_NUB; i++) begin
        rec     = bus.sort_out[i*WP +: WP];
        rec_dst = rec[DSTL +: IW];
        if (rec[VB]) begin
          if (ov_nxt[rec_dst]) dup_nxt = 1'b1;
          else begin
            ov_nxt[rec_dst]                         = 1'b1;
            os_nxt[rec_dst*IW +: IW]                = rec[SRCL +: IW];
            od_nxt[rec_dst*DATA_WIDTH +: DATA_WIDTH] = rec[DATA_WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q    <= '0;
      os_q    <= '0;
      od_q    <= '0;
      dup_err <= 1'b0;
    end else begin
      ov_q    <= ov_nxt;
      os_q    <= os_nxt;
      od_q    <= od_nxt;
      dup_err <= dup_err | dup_nxt;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_src   = os_q;
  assign bus.out_data  = od_q;

`ifdef SORT_SCHED_STATS_EN
  logic [31:0] grant_cnt_q, block_cnt_q, n_grant, n_block;

  always_comb begin
    n_grant = '0;
    n_block = '0;
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      n_grant = n_grant + 32'(granted[i]);
      n_block = n_block + 32'(run && bus.req_valid[i] && !granted[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      block_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_q + n_grant;
      block_cnt_q <= block_cnt_q + n_block;
    end
  end

  assign stat_grant_cnt = grant_cnt_q;
  assign stat_block_cnt = block_cnt_q;
`else
  assign stat_grant_cnt = '0;
  assign stat_block_cnt = '0;
`endif

endmodule

// File: tb/tb_sort_slot_scheduler.sv
// Directed self-checking bench for sort_slot_scheduler (4 ports, latency 3)
// with a delay-line sorter model that can inject a duplicate destination.
module tb_sort_slot_scheduler;
  localparam int unsigned PN  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned IW  = 2;
  localparam int unsigned WP  = 1 + 2 * IW + DW;
  localparam int unsigned VB  = DW + 2 * IW;
`ifdef SORT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sched_en, busy, dup_err, fault_en;
  logic [31:0] stat_grant_cnt, stat_block_cnt;
  logic [PN*WP-1:0] pipe [LAT];
  int unsigned n_checks = 0, n_errors = 0;

  sort_slot_scheduler_if #(.PORT_NUB(PN), .DATA_WIDTH(DW)) bus ();

  sort_slot_scheduler #(.PORT_NUB(PN), .DATA_WIDTH(DW), .SORT_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .sched_en       (sched_en),
    .bus            (bus.slave),
    .busy           (busy),
    .dup_err        (dup_err),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_block_cnt (stat_block_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= bus.sort_in;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  always_comb begin
    bus.sort_out = pipe[LAT-1];
    if (fault_en && pipe[LAT-1][VB] === 1'b1)
      bus.sort_out[3*WP +: WP] = {1'b1, 2'd2, 2'd3, 16'h5A5A};
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sched_en = 1'b0; fault_en = 1'b0;
    bus.req_valid = '0; bus.req_dst = '0; bus.req_data = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic enter_run();
    sched_en = 1'b1;
    tick(1);
  endtask

  // Inputs 0..3 -> dst 2,0,3,1; delivery 5 cycles later
  task automatic run_perm();
    logic [WP-1:0] lane0;
    bus.req_valid = 4'hF;
    bus.req_dst   = 8'h72;
    bus.req_data  = 64'hA003_A002_A001_A000;
    #1 check_val("perm_ready", bus.req_ready, 4'hF);
    tick(1);
    bus.req_valid = '0;
    lane0 = bus.sort_in[0 +: WP];
    check_val("perm_sortin_lane0", lane0, {1'b1, 2'd2, 2'd0, 16'hA000});
    for (int c = 1; c <= 4; c++) begin
      check_val("perm_quiet", bus.out_valid, 4'h0);
      tick(1);
    end
    check_val("perm_valid", bus.out_valid, 4'hF);
    check_val("perm_src", bus.out_src, 8'h8D);
    check_val("perm_data", bus.out_data, 64'hA002_A000_A003_A001);
    tick(1);
    check_val("perm_after", bus.out_valid, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [WP-1:0] lane;

    // reset state
    do_reset();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_out_valid", bus.out_valid, 4'h0);
    check_val("rst_out_src", bus.out_src, 8'h00);
    check_val("rst_out_data", bus.out_data, 64'h0);
    check_val("rst_dup", dup_err, 1'b0);
    check_val("rst_grant_cnt", stat_grant_cnt, 32'd0);
    check_val("rst_block_cnt", stat_block_cnt, 32'd0);
    lane = bus.sort_in[2*WP +: WP];
    check_val("rst_sortin_lane2", lane, {1'b0, 2'd0, 2'd2, 16'd0});
    bus.req_valid = 4'hF;
    #1 check_val("idle_noready", bus.req_ready, 4'h0);
    bus.req_valid = '0;

    // contention: inputs 0 and 2 both want dst 1
    enter_run();
    bus.req_valid = 4'b0101;
    bus.req_dst   = 8'h11;
    bus.req_data  = 64'h0000_2200_0000_1100;
    #1 check_val("cont_ready0", bus.req_ready, 4'b0001);
    tick(1);
    check_val("cont_ready1", bus.req_ready, 4'b0100);
    tick(1);
    check_val("cont_ready2", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;
    check_val("cont_block_cnt", stat_block_cnt, STATS ? 32'd3 : 32'd0);
    check_val("cont_grant_cnt", stat_grant_cnt, STATS ? 32'd3 : 32'd0);
    tick(2);
    check_val("cont_v0", bus.out_valid, 4'b0010);
    check_val("cont_s0", bus.out_src[1*IW +: IW], 2'd0);
    check_val("cont_d0", bus.out_data[1*DW +: DW], 16'h1100);
    tick(1);
    check_val("cont_v1", bus.out_valid, 4'b0010);
    check_val("cont_s1", bus.out_src[1*IW +: IW], 2'd2);
    check_val("cont_d1", bus.out_data[1*DW +: DW], 16'h2200);
    tick(1);
    check_val("cont_v2", bus.out_valid, 4'b0010);
    check_val("cont_s2", bus.out_src[1*IW +: IW], 2'd0);

    // permutation, ten times back to back
    do_reset();
    enter_run();
    repeat (10) run_perm();
    check_val("stats_grant_40", stat_grant_cnt, STATS ? 32'd40 : 32'd0);
    check_val("stats_block_0", stat_block_cnt, 32'd0);

    // drain: sched_en drops the cycle after a grant
    do_reset();
    enter_run();
    bus.req_valid = 4'b0001;
    bus.req_dst   = 8'h03;
    bus.req_data  = 64'h0000_0000_0000_D00D;
    #1 check_val("drain_grant", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;
    sched_en = 1'b0;
    check_val("drain_busy_t1", busy, 1'b1);
    tick(1);
    bus.req_valid = 4'b0010;
    bus.req_dst   = 8'h07;
    #1 check_val("drain_noready_t2", bus.req_ready, 4'h0);
    check_val("drain_busy_t2", busy, 1'b1);
    tick(1);
    sched_en = 1'b1;
    #1 check_val("drain_noready_t3", bus.req_ready, 4'h0);
    tick(1);
    check_val("drain_noready_t4", bus.req_ready, 4'h0);
    check_val("drain_busy_t4", busy, 1'b1);
    tick(1);
    check_val("drain_noready_t5", bus.req_ready, 4'h0);
    check_val("drain_busy_t5", busy, 1'b1);
    check_val("drain_out_valid", bus.out_valid, 4'b1000);
    check_val("drain_out_src", bus.out_src[3*IW +: IW], 2'd0);
    check_val("drain_out_data", bus.out_data[3*DW +: DW], 16'hD00D);
    tick(1);
    check_val("drain_idle_busy", busy, 1'b0);
    check_val("drain_idle_ready", bus.req_ready, 4'h0);
    tick(1);
    check_val("drain_rerun_ready", bus.req_ready, 4'b0010);
    bus.req_valid = '0;

    // reset two cycles after a grant
    do_reset();
    enter_run();
    bus.req_valid = 4'b0001;
    bus.req_dst   = 8'h00;
    bus.req_data  = 64'h0000_0000_0000_BEEF;
    #1 check_val("midrst_grant", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;
    sched_en = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_val("midrst_quiet", bus.out_valid, 4'h0);
      tick(1);
    end
    enter_run();
    bus.req_valid = 4'b1001;
    bus.req_dst   = 8'h00;
    #1 check_val("midrst_ptr0", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;

    // duplicate destination from the sorter
    do_reset();
    check_val("dup_pre", dup_err, 1'b0);
    enter_run();
    fault_en = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_dst   = 8'h02;
    bus.req_data  = 64'h0000_0000_0000_1234;
    #1 check_val("dup_grant", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;
    tick(4);
    check_val("dup_valid", bus.out_valid, 4'b0100);
    check_val("dup_src", bus.out_src[2*IW +: IW], 2'd0);
    check_val("dup_data", bus.out_data[2*DW +: DW], 16'h1234);
    check_val("dup_flag", dup_err, 1'b1);
    tick(5);
    check_val("dup_sticky", dup_err, 1'b1);
    check_val("dup_quiet", bus.out_valid, 4'h0);
    do_reset();
    check_val("dup_cleared", dup_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
